// File: rtl/gate_pkg.sv
// gate_pkg: shared definitions for the gate arbiter slice.
//   - op_e    : opcode encoding of the shared bitwise logic unit
//   - state_e : arbiter FSM state encoding
//   - pick_t  : result of a round-robin search (found flag + requester id)
//   - rr_pick : round-robin search over four requesters starting at ptr
package gate_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_NOT  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] id;
    } pick_t;

    // Search order is ptr, ptr+1, ... wrapping through the 2-bit id space.
    // The loop runs from the farthest candidate down to ptr so the nearest
    // valid requester is the last one written and therefore wins.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] valid,
                                      input logic [ID_W-1:0]    ptr);
        pick_t           p;
        logic [ID_W-1:0] cand;
        p.found = 1'b0;
        p.id    = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + ID_W'(k);
            if (valid[cand]) begin
                p.found = 1'b1;
                p.id    = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/gate_alu.sv
// gate_alu: shared combinational bitwise logic unit.
//   op   : OP_AND / OP_OR / OP_NOT / OP_NAND
//   a, b : operands (b unused for OP_NOT)
//   y    : selected result
// All four gate cells evaluate in parallel; a 4:1 select picks one.
module gate_alu
    import gate_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] y_and;
    logic [WIDTH-1:0] y_or;
    logic [WIDTH-1:0] y_not;
    logic [WIDTH-1:0] y_nand;

    gate_and  #(.WIDTH(WIDTH)) u_and  (.a(a), .b(b), .y(y_and));
    gate_or   #(.WIDTH(WIDTH)) u_or   (.a(a), .b(b), .y(y_or));
    gate_not  #(.WIDTH(WIDTH)) u_not  (.a(a),        .y(y_not));
    gate_nand #(.WIDTH(WIDTH)) u_nand (.a(a), .b(b), .y(y_nand));

    always_comb begin
        y = y_and;
        case (op)
            OP_AND:  y = y_and;
            OP_OR:   y = y_or;
            OP_NOT:  y = y_not;
            OP_NAND: y = y_nand;
            default: y = y_and;
        endcase
    end
endmodule

// File: rtl/gate_and.sv
// gate_and: WIDTH-bit bitwise AND cell.
//   a, b : operands
//   y    : a & b
module gate_and #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a & b;
endmodule

// File: rtl/gate_nand.sv
// gate_nand: WIDTH-bit bitwise NAND cell.
//   a, b : operands
//   y    : ~(a & b)
module gate_nand #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = ~(a & b);
endmodule

// File: rtl/gate_not.sv
// gate_not: WIDTH-bit bitwise complement cell.
//   a : operand
//   y : ~a (same width, no extension)
module gate_not #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);
    assign y = ~a;
endmodule

// File: rtl/gate_or.sv
// gate_or: WIDTH-bit bitwise OR cell.
//   a, b : operands
//   y    : a | b
module gate_or #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a | b;
endmodule

// File: rtl/gate_arbiter.sv
// gate_arbiter: time-shares one gate_alu among N (=4) requesters.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester pending flag
//   req_op     : per-requester 2-bit opcode, packed [2i+1:2i]
//   req_a/b    : per-requester operands, packed [WIDTH*i +: WIDTH]
//   req_ready  : one-hot combinational accept strobe (IDLE only)
//   rsp_valid  : registered result-valid (RESP only)
//   rsp_id     : requester that owns rsp_data
//   rsp_data   : registered result
//   rsp_ready  : consumer accepts the response
// Flow: IDLE (grant + capture) -> EXEC (compute, register) -> RESP (hold
// until rsp_ready). The round-robin pointer advances only when a response
// completes, so a discarded (reset) operation never moves it.
module gate_arbiter
    import gate_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_valid,
    input  logic [2*N-1:0]     req_op,
    input  logic [N*WIDTH-1:0] req_a,
    input  logic [N*WIDTH-1:0] req_b,
    output logic [N-1:0]       req_ready,
    output logic               rsp_valid,
    output logic [1:0]         rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    input  logic               rsp_ready
);
    state_e           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [WIDTH-1:0] a_arr  [N];
    logic [WIDTH-1:0] b_arr  [N];
    logic [1:0]       op_arr [N];
    logic [N-1:0]     grant;
    logic [WIDTH-1:0] alu_y;
    pick_t            pick;

    // Unpack the flat request buses into per-requester views.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
            assign b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];
            assign op_arr[gi] = req_op[2*gi +: 2];
        end
    endgenerate

    gate_alu #(.WIDTH(WIDTH)) u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y)
    );

    always_comb begin
        pick        = rr_pick(req_valid, ptr_q);
        grant       = '0;
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (pick.found) begin
                    grant[pick.id] = 1'b1;
                    op_d           = op_e'(op_arr[pick.id]);
                    a_d            = a_arr[pick.id];
                    b_d            = b_arr[pick.id];
                    id_d           = pick.id;
                    state_d        = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_y;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = id_q + ID_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            op_q        <= OP_AND;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // The grant is combinational, so it must be masked while reset is held.
    assign req_ready = rst ? '0 : grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_gate_arbiter.sv
// tb_gate_arbiter: directed stimulus for gate_arbiter. A transaction-level
// reference (round-robin pick by modular arithmetic, result by plain
// operators, response due two cycles after acceptance) is checked against
// the DUT every cycle on the falling edge, alongside hand-computed literals.
module tb_gate_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [2*N-1:0] req_op = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           rsp_ready = 1'b1;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int log_id[$];
    int log_cyc[$];

    gate_arbiter #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return ~a;
            default: return ~(a & b);
        endcase
    endfunction

    // Reference: phase 0 = free, 1 = accepted last cycle, 2 = response due.
    initial begin : compare
        int           m_phase;
        int           m_ptr;
        int           m_id;
        logic [W-1:0] m_res;
        logic [N-1:0] exp_ready;
        int           g;
        int           idx;
        m_phase = 0;
        m_ptr   = 0;
        m_id    = 0;
        m_res   = '0;
        forever begin
            @(negedge clk);
            exp_ready = '0;
            g = -1;
            if (!rst && m_phase == 0) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
            if (m_phase == 2) begin
                check("rsp_id", 64'(rsp_id), 64'(m_id));
                check("rsp_data", 64'(rsp_data), 64'(m_res));
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    log_id.push_back(i);
                    log_cyc.push_back(cyc);
                end
            end
            if (rsp_valid && rsp_ready)
                $display("RSP cycle=%0d id=%0d data=%h", cyc, rsp_id, rsp_data);
            if (rst) begin
                m_phase = 0;
                m_ptr   = 0;
            end else if (m_phase == 0) begin
                if (g >= 0) begin
                    m_id    = g;
                    m_res   = ref_op(req_op[2*g +: 2], req_a[W*g +: W], req_b[W*g +: W]);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (rsp_ready) begin
                m_phase = 0;
                m_ptr   = (m_id + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single_req(input int id, input logic [1:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] exp);
        logic [N-1:0] onehot;
        onehot = N'(1) << id;
        tick();
        req_valid           = onehot;
        req_op[2*id +: 2]   = op;
        req_a[W*id +: W]    = a;
        req_b[W*id +: W]    = b;
        @(negedge clk);
        check("single_ready", 64'(req_ready), 64'(onehot));
        tick();
        req_valid           = '0;
        req_a[W*id +: W]    = ~a;
        req_op[2*id +: 2]   = ~op;
        @(negedge clk);
        check("single_exec_valid", 64'(rsp_valid), 64'(0));
        tick();
        @(negedge clk);
        check("single_rsp_valid", 64'(rsp_valid), 64'(1));
        check("single_rsp_data", 64'(rsp_data), 64'(exp));
        check("single_rsp_id", 64'(rsp_id), 64'(id));
        tick();
    endtask

    initial begin
        rsp_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", 64'(rsp_valid), 64'(0));
        check("reset_data", 64'(rsp_data), 64'(0));
        check("reset_id", 64'(rsp_id), 64'(0));

        // Single requests: AND, NOT, NAND (leaves pointer at 3).
        single_req(0, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        single_req(1, 2'b10, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_0000);
        single_req(2, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);

        // Wrap-around: pointer 3 with requesters 3 and 0 pending.
        tick();
        req_valid = 4'b1001;
        req_op    = 8'b01_00_00_00;
        req_a     = {32'h0F0F_0F0F, 32'h0, 32'h0, 32'h1357_9BDF};
        req_b     = {32'hF0F0_0000, 32'h0, 32'h0, 32'hFFFF_0000};
        log_id.delete();
        log_cyc.delete();
        repeat (6) tick();
        req_valid = '0;
        repeat (3) tick();
        check("wrap_count", 64'(log_id.size()), 64'(2));
        if (log_id.size() >= 2) begin
            check("wrap_first", 64'(log_id[0]), 64'(3));
            check("wrap_second", 64'(log_id[1]), 64'(0));
            check("wrap_spacing", 64'(log_cyc[1] - log_cyc[0]), 64'(3));
        end

        // Reset while idle with requests pending, then all four contending.
        tick();
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_op    = 8'b11_10_01_00;
        req_a     = {32'h0F0F_1234, 32'hFFFF_0000, 32'h1111_2222, 32'hAAAA_5555};
        req_b     = {32'hFFFF_00FF, 32'h0000_0000, 32'h2222_1111, 32'h0F0F_F0F0};
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'(0));
        tick();
        rst = 1'b0;
        log_id.delete();
        log_cyc.delete();
        repeat (13) tick();
        req_valid = '0;
        repeat (3) tick();
        check("rr_count", 64'(log_id.size()), 64'(5));
        if (log_id.size() == 5) begin
            check("rr_order0", 64'(log_id[0]), 64'(0));
            check("rr_order1", 64'(log_id[1]), 64'(1));
            check("rr_order2", 64'(log_id[2]), 64'(2));
            check("rr_order3", 64'(log_id[3]), 64'(3));
            check("rr_order4", 64'(log_id[4]), 64'(0));
            for (int i = 1; i < 5; i++)
                check("rr_spacing", 64'(log_cyc[i] - log_cyc[i-1]), 64'(3));
        end

        // Backpressure: response held 5 cycles while operand a changes.
        tick();
        rsp_ready        = 1'b0;
        req_valid        = 4'b0100;
        req_op           = 8'b00_01_00_00;
        req_a[W*2 +: W]  = 32'h1234_5678;
        req_b[W*2 +: W]  = 32'h0F0F_0000;
        @(negedge clk);
        check("bp_grant", 64'(req_ready), 64'(4'b0100));
        tick();
        req_valid        = 4'b0101;
        req_a[W*2 +: W]  = 32'hDEAD_BEEF;
        req_a[W*0 +: W]  = 32'hAAAA_5555;
        req_b[W*0 +: W]  = 32'hFFFF_0000;
        for (int k = 0; k < 5; k++) begin
            tick();
            req_a[W*2 +: W] = $urandom;
            @(negedge clk);
            check("bp_data", 64'(rsp_data), 64'(32'h1F3F_5678));
            check("bp_id", 64'(rsp_id), 64'(2));
            check("bp_ready", 64'(req_ready), 64'(0));
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(req_ready), 64'(0));
        check("bp_release_valid", 64'(rsp_valid), 64'(1));
        tick();
        @(negedge clk);
        check("bp_next_grant", 64'(req_ready), 64'(4'b0001));
        tick();
        req_valid = '0;
        repeat (3) tick();

        // Reset during EXEC discards the operation and clears the pointer.
        tick();
        req_valid        = 4'b0010;
        req_op[3:2]      = 2'b01;
        req_a[W*1 +: W]  = 32'h5555_0000;
        req_b[W*1 +: W]  = 32'h0000_AAAA;
        @(negedge clk);
        check("rx_grant", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = '0;
        rst       = 1'b1;
        @(negedge clk);
        check("rx_exec_valid", 64'(rsp_valid), 64'(0));
        tick();
        rst       = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        check("rx_idle_valid", 64'(rsp_valid), 64'(0));
        check("rx_ptr_grant", 64'(req_ready), 64'(4'b0001));
        tick();
        req_valid = '0;
        @(negedge clk);
        check("rx_exec2_valid", 64'(rsp_valid), 64'(0));
        tick();
        @(negedge clk);
        check("rx_rsp_valid", 64'(rsp_valid), 64'(1));
        check("rx_rsp_id", 64'(rsp_id), 64'(0));
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
